// File: rtl/core_pkg.sv
// Shared front-end definitions: fetch FSM states, reset vector default and
// branch-condition encodings agreed between the branch evaluator and fetch.
package core_pkg;

  localparam logic [31:0] ResetVectorDefault = 32'h0000_0000;

  typedef enum logic [1:0] {
    StBoot  = 2'd0,
    StReq   = 2'd1,
    StHold  = 2'd2,
    StDrain = 2'd3
  } fetch_state_t;

  typedef enum logic [1:0] {
    CondNe   = 2'd0,
    CondAlu  = 2'd1,
    CondNalu = 2'd2,
    CondAl   = 2'd3
  } branch_cond_t;

endpackage

// File: rtl/fetch_hold_buf.sv
// Single-entry instruction/PC skid register used while decode is stalled.
module fetch_hold_buf #(
  parameter int unsigned WordSize = 32
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                load_i,
  input  logic                clear_i,
  input  logic [WordSize-1:0] instr_i,
  input  logic [WordSize-1:0] pc_i,
  output logic [WordSize-1:0] instr_o,
  output logic [WordSize-1:0] pc_o,
  output logic                valid_o
);

  logic [WordSize-1:0] instr_q, pc_q;
  logic                valid_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      instr_q <= '0;
      pc_q    <= '0;
      valid_q <= 1'b0;
    end else if (clear_i) begin
      valid_q <= 1'b0;
    end else if (load_i) begin
      instr_q <= instr_i;
      pc_q    <= pc_i;
      valid_q <= 1'b1;
    end
  end

  assign instr_o = instr_q;
  assign pc_o    = pc_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/fetch_redirect_unit.sv
// Fetch PC controller: req/ack instruction fetch, stall skid buffer, and
// branch redirect with wrong-path squash and one-cycle flush pulse.
module fetch_redirect_unit
  import core_pkg::*;
#(
  parameter int unsigned          WordSize    = 32,
  parameter logic [WordSize-1:0]  ResetVector = WordSize'(ResetVectorDefault)
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                branch_taken,
  input  logic [WordSize-1:0] branch_addr,
  input  logic                stall,
  input  logic                imem_ack,
  input  logic [WordSize-1:0] imem_rdata,
  output logic                imem_req,
  output logic [WordSize-1:0] imem_addr,
  output logic [WordSize-1:0] instr_out,
  output logic [WordSize-1:0] pc_out,
  output logic                instr_valid,
  output logic                flush,
  output logic                misaligned
);

  fetch_state_t        state_q, state_d;
  logic [WordSize-1:0] pc_q, pc_d;
  logic [WordSize-1:0] drain_addr_q, drain_addr_d;
  logic [WordSize-1:0] instr_q, instr_d;
  logic [WordSize-1:0] pc_out_q, pc_out_d;
  logic                valid_q, valid_d;
  logic                flush_q, flush_d;
  logic                misaligned_q, misaligned_d;

  logic                hold_load, hold_clear, hold_valid;
  logic [WordSize-1:0] hold_instr, hold_pc;

  logic                redirect;
  logic [WordSize-1:0] target;
  logic [WordSize-1:0] pc_next;

  assign redirect = branch_taken && (state_q != StBoot);
  assign target   = {branch_addr[WordSize-1:2], 2'b00};
  assign pc_next  = pc_q + WordSize'(4);

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    drain_addr_d = drain_addr_q;
    instr_d      = instr_q;
    pc_out_d     = pc_out_q;
    valid_d      = 1'b0;
    hold_load    = 1'b0;
    hold_clear   = 1'b0;
    flush_d      = redirect;
    misaligned_d = redirect && (branch_addr[1:0] != 2'b00);

    unique case (state_q)
      StBoot: state_d = StReq;
      StReq: begin
        if (redirect) begin
          pc_d = target;
          if (!imem_ack) begin
            // Old access is still in flight; keep presenting it until acked.
            drain_addr_d = pc_q;
            state_d      = StDrain;
          end
        end else if (imem_ack) begin
          if (!stall) begin
            instr_d  = imem_rdata;
            pc_out_d = pc_q;
            valid_d  = 1'b1;
            pc_d     = pc_next;
          end else begin
            hold_load = 1'b1;
            state_d   = StHold;
          end
        end
      end
      StHold: begin
        if (redirect) begin
          pc_d       = target;
          hold_clear = 1'b1;
          state_d    = StReq;
        end else if (!stall) begin
          pc_d       = pc_next;
          hold_clear = 1'b1;
          state_d    = StReq;
        end
      end
      StDrain: begin
        if (redirect) pc_d = target;
        if (imem_ack) state_d = StReq;
      end
      default: state_d = StBoot;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= StBoot;
      pc_q         <= ResetVector;
      drain_addr_q <= ResetVector;
      instr_q      <= '0;
      pc_out_q     <= '0;
      valid_q      <= 1'b0;
      flush_q      <= 1'b0;
      misaligned_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      drain_addr_q <= drain_addr_d;
      instr_q      <= instr_d;
      pc_out_q     <= pc_out_d;
      valid_q      <= valid_d;
      flush_q      <= flush_d;
      misaligned_q <= misaligned_d;
    end
  end

  fetch_hold_buf #(
    .WordSize (WordSize)
  ) u_hold_buf (
    .clk_i   (clk),
    .rst_ni  (rstn),
    .load_i  (hold_load),
    .clear_i (hold_clear),
    .instr_i (imem_rdata),
    .pc_i    (pc_q),
    .instr_o (hold_instr),
    .pc_o    (hold_pc),
    .valid_o (hold_valid)
  );

  assign imem_req    = (state_q == StReq) || (state_q == StDrain);
  assign imem_addr   = (state_q == StDrain) ? drain_addr_q : pc_q;
  assign instr_out   = (state_q == StHold) ? hold_instr : instr_q;
  assign pc_out      = (state_q == StHold) ? hold_pc : pc_out_q;
  assign instr_valid = (state_q == StHold) ? hold_valid : valid_q;
  assign flush       = flush_q;
  assign misaligned  = misaligned_q;

endmodule

// File: tb/tb_fetch_redirect_unit.sv
// Directed, table-driven bench for fetch_redirect_unit with a simple
// combinational instruction memory model.
module tb_fetch_redirect_unit;

  localparam logic [31:0] Key = 32'hC0DE_0000;

  logic        clk = 1'b0;
  logic        rstn;
  logic        branch_taken;
  logic [31:0] branch_addr;
  logic        stall;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] instr_out;
  logic [31:0] pc_out;
  logic        instr_valid;
  logic        flush;
  logic        misaligned;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  assign imem_rdata = imem_ack ? (imem_addr ^ Key) : 32'h0;

  fetch_redirect_unit #(
    .WordSize    (32),
    .ResetVector (32'h0000_0000)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .branch_taken (branch_taken),
    .branch_addr  (branch_addr),
    .stall        (stall),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .instr_out    (instr_out),
    .pc_out       (pc_out),
    .instr_valid  (instr_valid),
    .flush        (flush),
    .misaligned   (misaligned)
  );

  typedef struct {
    logic        br;
    logic [31:0] baddr;
    logic        stl;
    logic        ack;
    logic        ereq;
    logic [31:0] eaddr;
    logic        evalid;
    logic [31:0] epc;
    logic        eflush;
    logic        emis;
  } vec_t;

  localparam int NVec = 21;
  vec_t vecs[NVec];

  function automatic vec_t mk(logic br, logic [31:0] baddr, logic stl, logic ack,
                              logic ereq, logic [31:0] eaddr, logic evalid,
                              logic [31:0] epc, logic eflush, logic emis);
    vec_t v;
    v.br = br; v.baddr = baddr; v.stl = stl; v.ack = ack;
    v.ereq = ereq; v.eaddr = eaddr; v.evalid = evalid; v.epc = epc;
    v.eflush = eflush; v.emis = emis;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic br, input logic [31:0] baddr, input logic stl,
                       input logic ack);
    branch_taken = br;
    branch_addr  = baddr;
    stall        = stl;
    imem_ack     = ack;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Cols: br, baddr, stall, ack | req, addr, valid, pc_out, flush, misaligned
    vecs[0]  = mk(1, 32'h500, 0, 0,  1, 32'h000, 0, 32'h0,   0, 0); // branch in BOOT ignored
    vecs[1]  = mk(0, 32'h0,   0, 1,  1, 32'h004, 1, 32'h000, 0, 0);
    vecs[2]  = mk(0, 32'h0,   0, 1,  1, 32'h008, 1, 32'h004, 0, 0);
    vecs[3]  = mk(0, 32'h0,   1, 1,  0, 32'h0,   1, 32'h008, 0, 0); // ack under stall -> HOLD
    vecs[4]  = mk(0, 32'h0,   1, 0,  0, 32'h0,   1, 32'h008, 0, 0);
    vecs[5]  = mk(0, 32'h0,   1, 0,  0, 32'h0,   1, 32'h008, 0, 0);
    vecs[6]  = mk(0, 32'h0,   0, 0,  1, 32'h00C, 0, 32'h0,   0, 0);
    vecs[7]  = mk(0, 32'h0,   0, 1,  1, 32'h010, 1, 32'h00C, 0, 0);
    vecs[8]  = mk(0, 32'h0,   0, 0,  1, 32'h010, 0, 32'h0,   0, 0);
    vecs[9]  = mk(1, 32'h100, 0, 0,  1, 32'h010, 0, 32'h0,   1, 0); // -> DRAIN
    vecs[10] = mk(0, 32'h0,   0, 0,  1, 32'h010, 0, 32'h0,   0, 0);
    vecs[11] = mk(0, 32'h0,   0, 1,  1, 32'h100, 0, 32'h0,   0, 0); // drained data dropped
    vecs[12] = mk(1, 32'h040, 1, 1,  1, 32'h040, 0, 32'h0,   1, 0); // redirect beats ack+stall
    vecs[13] = mk(1, 32'h203, 0, 1,  1, 32'h200, 0, 32'h0,   1, 1); // misaligned target
    vecs[14] = mk(0, 32'h0,   0, 1,  1, 32'h204, 1, 32'h200, 0, 0);
    vecs[15] = mk(0, 32'h0,   1, 1,  0, 32'h0,   1, 32'h204, 0, 0);
    vecs[16] = mk(1, 32'h300, 1, 0,  1, 32'h300, 0, 32'h0,   1, 0); // redirect out of HOLD
    vecs[17] = mk(1, 32'h400, 0, 0,  1, 32'h300, 0, 32'h0,   1, 0);
    vecs[18] = mk(1, 32'h500, 0, 0,  1, 32'h300, 0, 32'h0,   1, 0); // newest target wins
    vecs[19] = mk(0, 32'h0,   0, 1,  1, 32'h500, 0, 32'h0,   0, 0);
    vecs[20] = mk(0, 32'h0,   0, 1,  1, 32'h504, 1, 32'h500, 0, 0);

    rstn = 1'b0;
    drive(0, 32'h0, 0, 0);
    #12;
    check("reset imem_req", 32'(imem_req), 32'd0);
    check("reset imem_addr", imem_addr, 32'h0);
    check("reset instr_valid", 32'(instr_valid), 32'd0);
    check("reset instr_out", instr_out, 32'h0);
    check("reset pc_out", pc_out, 32'h0);
    check("reset flush", 32'(flush), 32'd0);
    check("reset misaligned", 32'(misaligned), 32'd0);
    @(posedge clk);
    #1;
    rstn = 1'b1;

    for (int i = 0; i < NVec; i++) begin
      drive(vecs[i].br, vecs[i].baddr, vecs[i].stl, vecs[i].ack);
      tick();
      check($sformatf("v%0d imem_req", i), 32'(imem_req), 32'(vecs[i].ereq));
      if (vecs[i].ereq) check($sformatf("v%0d imem_addr", i), imem_addr, vecs[i].eaddr);
      check($sformatf("v%0d instr_valid", i), 32'(instr_valid), 32'(vecs[i].evalid));
      if (vecs[i].evalid) begin
        check($sformatf("v%0d pc_out", i), pc_out, vecs[i].epc);
        check($sformatf("v%0d instr_out", i), instr_out, vecs[i].epc ^ Key);
      end
      check($sformatf("v%0d flush", i), 32'(flush), 32'(vecs[i].eflush));
      check($sformatf("v%0d misaligned", i), 32'(misaligned), 32'(vecs[i].emis));
    end

    // PC wrap at the top of the address space.
    drive(1, 32'hFFFF_FFFC, 0, 1);
    tick();
    check("wrap redirect addr", imem_addr, 32'hFFFF_FFFC);
    drive(0, 32'h0, 0, 1);
    tick();
    check("wrap pc_out", pc_out, 32'hFFFF_FFFC);
    check("wrap instr_valid", 32'(instr_valid), 32'd1);
    check("wrap next addr", imem_addr, 32'h0);
    drive(0, 32'h0, 0, 1);
    tick();
    check("post-wrap addr", imem_addr, 32'h4);
    drive(0, 32'h0, 0, 0);
    tick();
    check("outstanding req", 32'(imem_req), 32'd1);

    // Asynchronous reset mid-request, between clock edges.
    #2;
    rstn = 1'b0;
    #1;
    check("async rst imem_req", 32'(imem_req), 32'd0);
    check("async rst imem_addr", imem_addr, 32'h0);
    check("async rst instr_valid", 32'(instr_valid), 32'd0);
    check("async rst pc_out", pc_out, 32'h0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    tick();
    check("reboot imem_req", 32'(imem_req), 32'd1);
    check("reboot imem_addr", imem_addr, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
